// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI master controller.
package spi_pkg;

    localparam int unsigned SPI_ADDR_W  = 7;
    localparam int unsigned SPI_DATA_W  = 8;
    localparam logic        SPI_RW_READ = 1'b1;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE  = 3'd0;
    localparam spi_state_t ST_SETUP = 3'd1;
    localparam spi_state_t ST_ADDR  = 3'd2;
    localparam spi_state_t ST_TURN  = 3'd3;
    localparam spi_state_t ST_DATA  = 3'd4;
    localparam spi_state_t ST_HOLD  = 3'd5;
    localparam spi_state_t ST_GAP   = 3'd6;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider: emits a tick every CLK_DIV cycles while enabled and
// toggles sclk on ticks only while run is asserted.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic run,
    output logic sclk,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    assign tick = en && (div == DIV_LAST);
    assign rise = tick && run && !sclk;
    assign fall = tick && run && sclk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            div  <= '0;
            sclk <= 1'b0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (rise)
                sclk <= 1'b1;
            else if (fall)
                sclk <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-byte SPI read/write initiator (CPOL=0). Optional loopback capture
// is enabled by defining SPIM_LOOPBACK_EN.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned TURN_BITS = 1,
    parameter int unsigned CS_IDLE   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rw,
    input  logic [SPI_ADDR_W-1:0] addr,
    input  logic [SPI_DATA_W-1:0] wdata,
    output logic [SPI_DATA_W-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  cs,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
`ifdef SPIM_LOOPBACK_EN
    ,
    input  logic                  loopback
`endif
);

    localparam logic       HAS_TURN  = (TURN_BITS > 0);
    localparam logic [2:0] TURN_LAST = 3'((TURN_BITS > 0) ? TURN_BITS - 1 : 0);
    localparam int unsigned GAP_TICKS = 2 * CS_IDLE;
    localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

    spi_state_t            state;
    logic [SPI_DATA_W-2:0] sr;
    logic [SPI_DATA_W-1:0] rx;
    logic [SPI_DATA_W-1:0] wdata_q;
    logic [SPI_DATA_W-1:0] data_first;
    logic                  rw_q;
    logic [3:0]            bit_cnt;
    logic [2:0]            turn_cnt;
    logic [GW-1:0]         gap_cnt;
    logic                  en, run, tick, rise, fall;
    logic                  cap_en, cap_bit;

    assign en  = (state != ST_IDLE);
    assign run = (state == ST_SETUP) || (state == ST_ADDR) ||
                 (state == ST_TURN)  || (state == ST_DATA);
    assign data_first = (rw_q == SPI_RW_READ) ? '0 : wdata_q;

`ifdef SPIM_LOOPBACK_EN
    assign cap_en  = loopback || (rw_q == SPI_RW_READ);
    assign cap_bit = loopback ? mosi : miso;
`else
    assign cap_en  = (rw_q == SPI_RW_READ);
    assign cap_bit = miso;
`endif

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .run   (run),
        .sclk  (sclk),
        .tick  (tick),
        .rise  (rise),
        .fall  (fall)
    );

    // mosi always equals the current bit; sr holds the bits still to send.
    // Frame transitions happen on the fall that ends a frame's last high half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cs       <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= '0;
            sr       <= '0;
            rx       <= '0;
            wdata_q  <= '0;
            rw_q     <= 1'b0;
            bit_cnt  <= '0;
            turn_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rw_q     <= rw;
                        wdata_q  <= wdata;
                        sr       <= {addr[SPI_ADDR_W-2:0], rw};
                        mosi     <= addr[SPI_ADDR_W-1];
                        cs       <= 1'b0;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        turn_cnt <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (rise)
                        state <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (fall) begin
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if ((rw_q == SPI_RW_READ) && HAS_TURN) begin
                                sr    <= '0;
                                mosi  <= 1'b0;
                                state <= ST_TURN;
                            end else begin
                                sr    <= data_first[SPI_DATA_W-2:0];
                                mosi  <= data_first[SPI_DATA_W-1];
                                state <= ST_DATA;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            sr      <= {sr[SPI_DATA_W-3:0], 1'b0};
                            mosi    <= sr[SPI_DATA_W-2];
                        end
                    end
                end
                ST_TURN: begin
                    if (fall) begin
                        if (turn_cnt == TURN_LAST) begin
                            sr    <= data_first[SPI_DATA_W-2:0];
                            mosi  <= data_first[SPI_DATA_W-1];
                            state <= ST_DATA;
                        end else begin
                            turn_cnt <= turn_cnt + 3'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (rise && cap_en)
                        rx <= {rx[SPI_DATA_W-2:0], cap_bit};
                    if (fall) begin
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            mosi    <= 1'b0;
                            state   <= ST_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            sr      <= {sr[SPI_DATA_W-3:0], 1'b0};
                            mosi    <= sr[SPI_DATA_W-2];
                        end
                    end
                end
                ST_HOLD: begin
                    // Two half-periods: the last bit's low half, then the hold itself.
                    if (tick) begin
                        if (bit_cnt == 4'd1) begin
                            bit_cnt <= '0;
                            cs      <= 1'b1;
                            done    <= 1'b1;
                            if (cap_en)
                                rdata <= rx;
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl at CLK_DIV=4, TURN_BITS=1, CS_IDLE=1.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy, done, cs, sclk, mosi, miso;
    logic       miso_bit;
    logic       miso_tie;
`ifdef SPIM_LOOPBACK_EN
    logic       loopback;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_master_ctrl #(.CLK_DIV(4), .TURN_BITS(1), .CS_IDLE(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .cs       (cs),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso)
`ifdef SPIM_LOOPBACK_EN
        ,
        .loopback (loopback)
`endif
    );

    // Bus monitor, sampled 1 time unit after each rising clk edge.
    int   cyc = 0;
    int   rise_cnt = 0;
    int   cs_falls = 0;
    int   cs_fall_cyc = 0;
    int   last_cs_rise = 0;
    int   cs_low_len = 0;
    int   busy_rises = 0;
    int   busy_start = 0;
    int   busy_len = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic mosi_bits [64];
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;
    logic [7:0] tgt_byte = 8'h00;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (prev_cs && !cs) begin
            cs_falls++;
            cs_fall_cyc = cyc;
            rise_cnt = 0;
        end
        if (!prev_cs && cs) begin
            cs_low_len = cyc - cs_fall_cyc;
            last_cs_rise = cyc;
        end
        if (!prev_sclk && sclk) begin
            if (rise_cnt < 64) mosi_bits[rise_cnt] = mosi;
            rise_cnt++;
        end
        if (!prev_busy && busy) begin
            busy_rises++;
            busy_start = cyc;
        end
        if (prev_busy && !busy) busy_len = cyc - busy_start;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_cs = cs;
        prev_sclk = sclk;
        prev_busy = busy;
    end

    // Target model: read data follows 8 address rises and 1 turnaround rise.
    always @(negedge sclk or posedge cs) begin
        if (!cs && rise_cnt >= 9 && rise_cnt <= 16)
            miso_bit = tgt_byte[7 - (rise_cnt - 9)];
        else
            miso_bit = 1'b0;
    end
    assign miso = miso_tie | miso_bit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input int first);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = mosi_bits[first + i];
        return b;
    endfunction

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] tgt;
        logic [7:0] exp_abyte;
        logic [7:0] exp_dbyte;
        logic [7:0] exp_rdata;
        int         exp_cs_low;
        int         exp_rises;
    } vec_t;

    task automatic wait_idle(input string name);
        logic timed_out;
        timed_out = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        chk(name, 32'(timed_out), 32'd0);
    endtask

    task automatic do_txn(input string tag, input vec_t v);
        int d0;
        d0 = done_cnt;
        tgt_byte = v.tgt;
        @(negedge clk);
        rw = v.rw; addr = v.addr; wdata = v.wdata; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle({tag, "_timeout"});
        chk({tag, "_addr_byte"}, 32'(get_byte(0)), 32'(v.exp_abyte));
        chk({tag, "_data_byte"}, 32'(get_byte(v.rw ? 9 : 8)), 32'(v.exp_dbyte));
        chk({tag, "_sclk_rises"}, 32'(rise_cnt), 32'(v.exp_rises));
        chk({tag, "_cs_low"}, 32'(cs_low_len), 32'(v.exp_cs_low));
        chk({tag, "_busy_len"}, 32'(busy_len), 32'(v.exp_cs_low + 8));
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_done_latency"}, 32'(done_cyc - busy_start), 32'(v.exp_cs_low));
        chk({tag, "_rdata"}, 32'(rdata), 32'(v.exp_rdata));
    endtask

    vec_t vecs [6];

    initial begin
        int d0, b0, f0;
        logic timed_out;
        vec_t v;

        vecs[0] = '{1'b0, 7'h2A, 8'hC3, 8'h00, 8'h54, 8'hC3, 8'h00, 136, 16};
        vecs[1] = '{1'b1, 7'h05, 8'h00, 8'hA5, 8'h0B, 8'h00, 8'hA5, 144, 17};
        vecs[2] = '{1'b0, 7'h7F, 8'h01, 8'h00, 8'hFE, 8'h01, 8'hA5, 136, 16};
        vecs[3] = '{1'b1, 7'h40, 8'h00, 8'h3C, 8'h81, 8'h00, 8'h3C, 144, 17};
        vecs[4] = '{1'b0, 7'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h3C, 136, 16};
        vecs[5] = '{1'b1, 7'h7F, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 144, 17};

        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        miso_tie = 1'b0; miso_bit = 1'b0;
`ifdef SPIM_LOOPBACK_EN
        loopback = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_cs", 32'(cs), 32'd1);
        chk("reset_sclk", 32'(sclk), 32'd0);
        chk("reset_mosi", 32'(mosi), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

        // start pulsed mid-write must be ignored.
        d0 = done_cnt; b0 = busy_rises; f0 = cs_falls;
        @(negedge clk);
        rw = 1'b0; addr = 7'h15; wdata = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        rw = 1'b1; addr = 7'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignore_timeout");
        repeat (30) @(negedge clk);
        chk("ignore_done_count", 32'(done_cnt - d0), 32'd1);
        chk("ignore_busy_rises", 32'(busy_rises - b0), 32'd1);
        chk("ignore_cs_falls", 32'(cs_falls - f0), 32'd1);
        chk("ignore_busy_len", 32'(busy_len), 32'd144);
        chk("ignore_cs_low", 32'(cs_low_len), 32'd136);
        chk("ignore_rdata", 32'(rdata), 32'h00);

        // Reset during address bit 3 aborts without done.
        d0 = done_cnt;
        @(negedge clk);
        rw = 1'b1; addr = 7'h33; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (rise_cnt == 4 && sclk) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk("abort_reach_bit3", 32'(timed_out), 32'd0);
        reset = 1'b1;
        #1;
        chk("abort_cs", 32'(cs), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_no_restart", 32'(cs), 32'd1);
        v = '{1'b1, 7'h7F, 8'h00, 8'h96, 8'hFF, 8'h00, 8'h96, 144, 17};
        do_txn("after_reset", v);

        // start held high: back-to-back writes separated by the CS gap.
        f0 = cs_falls; d0 = done_cnt;
        tgt_byte = 8'h00;
        @(negedge clk);
        rw = 1'b0; addr = 7'h11; wdata = 8'h22; start = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cs_falls == f0 + 2) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        chk("b2b_timeout", 32'(timed_out), 32'd0);
        chk("b2b_gap", 32'(cs_fall_cyc - last_cs_rise), 32'd9);
        chk("b2b_first_done", 32'(done_cnt - d0), 32'd1);
        wait_idle("b2b_idle_timeout");
        chk("b2b_second_done", 32'(done_cnt - d0), 32'd2);
        chk("b2b_data_byte", 32'(get_byte(8)), 32'h22);

`ifdef SPIM_LOOPBACK_EN
        loopback = 1'b1;
        miso_tie = 1'b1;
        v = '{1'b0, 7'h12, 8'h3C, 8'h00, 8'h24, 8'h3C, 8'h3C, 136, 16};
        do_txn("loopback", v);
        loopback = 1'b0;
        miso_tie = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
